// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches over req/ack, holds the instruction for EXEC_CYCLES, then strobes a one-cycle commit
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          EXEC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        npc_sel,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        wb_en
);
  typedef enum logic [1:0] {FETCH, EXEC, COMMIT} state_t;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic [3:0] cnt_q, cnt_d;
  logic fire, exec_go;
  always_comb begin
    imem_req = rst_n & (state_q == FETCH) & ~stall;
    fire     = imem_req & imem_ack;
    exec_go  = (state_q == EXEC) & ~stall;
    state_d  = fire ? EXEC
             : (exec_go & (cnt_q == 4'd0)) ? COMMIT
             : (state_q == COMMIT) ? FETCH
             : state_q;
    cnt_d    = fire ? CNT_INIT : (exec_go & (cnt_q != 4'd0)) ? cnt_q - 4'd1 : cnt_q;
    inst_d   = fire ? imem_data : inst_q;
    pc_d     = (state_q == COMMIT)
             ? pc_q + 32'd4 + (npc_sel ? {{14{inst_q[15]}}, inst_q[15:0], 2'b00} : 32'd0)
             : pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = state_q != FETCH;
  assign wb_en      = state_q == COMMIT;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized memory/stall driver with commit scoreboard for fetch_sequencer
module tb_fetch_sequencer;
  localparam int EXEC_CYCLES = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic imem_ack, stall, npc_sel;
  logic [31:0] imem_data;
  logic imem_req, inst_valid, wb_en;
  logic [31:0] imem_addr, pc, inst;
  logic w_req, w_iv, w_wb;
  logic [31:0] w_addr, w_pc, w_inst;
  typedef struct {int cyc; logic [31:0] pc; logic [31:0] inst; logic [31:0] pcw;} commit_t;
  commit_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic exp_req, exp_iv;
  logic [31:0] exp_pc, exp_pc_w, exp_inst;
  fetch_sequencer #(.RESET_PC(32'h0000_0000), .EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .stall(stall), .npc_sel(npc_sel), .pc(pc), .inst(inst),
    .inst_valid(inst_valid), .wb_en(wb_en));
  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .EXEC_CYCLES(EXEC_CYCLES)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .stall(stall), .npc_sel(npc_sel), .pc(w_pc), .inst(w_inst),
    .inst_valid(w_iv), .wb_en(w_wb));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] next_pc(input logic [31:0] p, input logic [31:0] d, input logic br);
    int off;
    off = br ? 4 * int'($signed(d[15:0])) : 0;
    return p + 32'(4 + off);
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      check("imem_req", imem_req, exp_req);
      check("inst_valid", inst_valid, exp_iv);
      if (imem_req) check("imem_addr", imem_addr, exp_pc);
      if (w_req) check("wrap_imem_addr", w_addr, exp_pc_w);
      if (exp_iv) begin
        check("inst_held", inst, exp_inst);
        check("pc_held", pc, exp_pc);
      end
      if (wb_en) begin
        if (q.size() == 0) check("wb_en_spurious", wb_en, 1'b0);
        else begin
          commit_t e;
          e = q.pop_front();
          check("commit_cycle", cyc, e.cyc);
          check("commit_pc", pc, e.pc);
          check("commit_inst", inst, e.inst);
          check("wrap_commit_pc", w_pc, e.pcw);
        end
      end
    end
  end
  task automatic run_inst(input logic [31:0] d, input logic npc, input int lat, input int fmode, input int emode);
    int ack_cyc, ns, run;
    for (int i = 0; i < lat; i++) begin
      stall = fmode == 1 ? 1'b1 : fmode == 2 ? ($urandom % 3 == 0) : 1'b0;
      imem_ack = fmode == 1 ? 1'b1 : stall ? 1'($urandom) : 1'b0;
      imem_data = $urandom;
      npc_sel = 1'($urandom);
      exp_req = ~stall;
      exp_iv = 1'b0;
      adv();
    end
    stall = 1'b0;
    imem_ack = 1'b1;
    imem_data = d;
    exp_req = 1'b1;
    exp_iv = 1'b0;
    ack_cyc = cyc;
    adv();
    exp_inst = d;
    exp_iv = 1'b1;
    exp_req = 1'b0;
    ns = 0;
    run = 0;
    while (run < EXEC_CYCLES) begin
      stall = emode == 1 ? ($urandom % 4 == 0) : emode == 2 ? (run == 1 && ns < 3) : 1'b0;
      imem_ack = 1'($urandom);
      imem_data = $urandom;
      npc_sel = 1'($urandom);
      if (stall) ns++;
      else run++;
      adv();
    end
    stall = 1'($urandom);
    imem_ack = 1'($urandom);
    imem_data = $urandom;
    npc_sel = npc;
    q.push_back('{ack_cyc + EXEC_CYCLES + 1 + ns, exp_pc, d, exp_pc_w});
    adv();
    exp_pc = next_pc(exp_pc, d, npc);
    exp_pc_w = next_pc(exp_pc_w, d, npc);
    exp_iv = 1'b0;
    stall = 1'b0;
    imem_ack = 1'b0;
    exp_req = 1'b1;
  endtask
  task automatic reset_mid(input int k);
    stall = 1'b0;
    imem_ack = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    exp_req = 1'b1;
    exp_iv = 1'b0;
    adv();
    exp_inst = 32'hDEAD_BEEF;
    exp_iv = 1'b1;
    exp_req = 1'b0;
    imem_ack = 1'b0;
    for (int i = 0; i < k; i++) adv();
    npc_sel = 1'b1;
    #1 rst_n = 1'b0;
    exp_iv = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    adv();
    rst_n = 1'b1;
    exp_pc = 32'h0;
    exp_pc_w = 32'hFFFF_FFFC;
    exp_req = 1'b1;
    #1;
    check("release_imem_req", imem_req, 1'b1);
    check("release_imem_addr", imem_addr, 32'h0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end
  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    stall = 1'b0;
    imem_ack = 1'b0;
    imem_data = '0;
    npc_sel = 1'b0;
    exp_req = 1'b0;
    exp_iv = 1'b0;
    exp_inst = '0;
    exp_pc = 32'h0;
    exp_pc_w = 32'hFFFF_FFFC;
    adv();
    check("init_imem_req", imem_req, 1'b0);
    check("init_wb_en", wb_en, 1'b0);
    check("init_inst_valid", inst_valid, 1'b0);
    check("init_pc", pc, 32'h0);
    check("init_wrap_pc", w_pc, 32'hFFFF_FFFC);
    adv();
    rst_n = 1'b1;
    exp_req = 1'b1;
    run_inst(32'h0022_1821, 1'b0, 0, 0, 0);
    run_inst(32'h0022_1822, 1'b0, 0, 0, 0);
    run_inst(32'h0000_0000, 1'b0, 0, 0, 0);
    run_inst(32'h0000_0000, 1'b0, 0, 0, 0);
    run_inst(32'h1000_FFFC, 1'b1, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_inst(32'h0000_0000, 1'b0, 0, 0, 0);
    run_inst(32'h1000_FFFC, 1'b0, 0, 0, 0);
    run_inst(32'h0123_4567, 1'b0, 0, 0, 2);
    run_inst(32'h89AB_CDEF, 1'b0, 3, 1, 0);
    run_inst(32'h0000_0008, 1'b1, 5, 0, 0);
    reset_mid(2);
    run_inst(32'h0022_1821, 1'b0, 1, 0, 0);
    reset_mid(EXEC_CYCLES);
    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      run_inst(d, 1'($urandom), $urandom_range(0, 5), 2, 1);
    end
    for (int i = 0; i < 3; i++) adv();
    check("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
